// File: rtl/pipelined_barrel_shifter.sv
// Pipelined barrel shifter: one registered log2 stage per shift-amount bit,
// supporting logical, arithmetic and rotate shifts behind a valid/ready stream.
module pipelined_barrel_shifter #(
    parameter  int WIDTH = 8,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SHW-1:0]   in_shamt,
    input  logic             in_dir,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    typedef enum logic [1:0] {
        MODE_LOGIC  = 2'b00,
        MODE_ARITH  = 2'b01,
        MODE_ROTATE = 2'b10,
        MODE_RSVD   = 2'b11
    } mode_e;

    // sign is the operand MSB captured at acceptance, used as arithmetic fill.
    typedef struct packed {
        logic             valid;
        logic             sign;
        logic             dir;
        mode_e            mode;
        logic [SHW-1:0]   shamt;
        logic [WIDTH-1:0] data;
    } stage_t;

    // stg[0] is the accepted input; stg[k+1] is the register of stage k.
    stage_t stg [SHW+1];
    logic   adv;

    assign adv      = out_ready || !stg[SHW].valid;
    assign in_ready = adv;

    assign stg[0] = '{
        valid: in_valid,
        sign:  in_data[WIDTH-1],
        dir:   in_dir,
        mode:  mode_e'(in_mode),
        shamt: in_shamt,
        data:  in_data
    };

    function automatic logic [WIDTH-1:0] shift_by(input stage_t s, input int amt);
        logic [WIDTH-1:0] fill;
        fill = ~({WIDTH{1'b1}} >> amt);
        if (s.mode == MODE_ROTATE)
            return s.dir ? ((s.data >> amt) | (s.data << (WIDTH - amt)))
                         : ((s.data << amt) | (s.data >> (WIDTH - amt)));
        else if (!s.dir)
            return s.data << amt;
        else if (s.mode == MODE_ARITH && s.sign)
            return (s.data >> amt) | fill;
        else
            return s.data >> amt;
    endfunction

    for (genvar k = 0; k < SHW; k++) begin : g_stage
        stage_t q;

        // NOTE: sequential state uses <= so every stage samples its upstream
        // neighbour's pre-edge value; blocking here would collapse the pipe.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                q <= '0;
            end else if (adv) begin
                q.valid <= stg[k].valid;
                // NOTE: payload loads only with a valid item; bubbles clear just
                // the valid bit so idle data does not toggle.
                if (stg[k].valid) begin
                    q.sign  <= stg[k].sign;
                    q.dir   <= stg[k].dir;
                    q.mode  <= stg[k].mode;
                    q.shamt <= stg[k].shamt;
                    q.data  <= stg[k].shamt[k] ? shift_by(stg[k], 1 << k) : stg[k].data;
                end
            end
        end

        assign stg[k+1] = q;
    end

    assign out_valid = stg[SHW].valid;
    assign out_data  = stg[SHW].data;

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Self-checking bench: directed spec cases, streaming/backpressure, bubbles,
// mid-flight reset and randomized traffic against a bit-level reference model.
module tb_pipelined_barrel_shifter;

    logic       clk = 1'b0;
    logic       rst;

    logic       in_valid, in_ready, in_dir, out_valid, out_ready;
    logic [7:0] in_data, out_data;
    logic [2:0] in_shamt;
    logic [1:0] in_mode;

    logic        in_valid16, in_ready16, in_dir16, out_valid16, out_ready16;
    logic [15:0] in_data16, out_data16;
    logic [3:0]  in_shamt16;
    logic [1:0]  in_mode16;

    always #5 clk = ~clk;

    pipelined_barrel_shifter #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_shamt(in_shamt), .in_dir(in_dir), .in_mode(in_mode),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
    );

    pipelined_barrel_shifter #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid16), .in_ready(in_ready16), .in_data(in_data16),
        .in_shamt(in_shamt16), .in_dir(in_dir16), .in_mode(in_mode16),
        .out_valid(out_valid16), .out_ready(out_ready16), .out_data(out_data16)
    );

    typedef struct {
        logic [7:0] data;
        int         step;
    } exp_t;

    exp_t       sb[$];
    int         n_checks = 0;
    int         n_fail   = 0;
    int         step     = 0;
    int         n_out    = 0;
    int         last_out_step = 0;
    logic [7:0] last_out;
    logic       accepted;
    logic       lat_chk  = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (step %0d)", tag, got, exp, step);
        end
    endtask

    // Output bit i takes source bit i-sh (left) or i+sh (right); out-of-range
    // sources wrap for rotate, copy the MSB for arithmetic right, else are 0.
    function automatic logic [31:0] ref_shift(input int w, input logic [31:0] d, input int sh,
                                              input logic dir, input logic [1:0] mode);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < w; i++) begin
            int j;
            j = dir ? i + sh : i - sh;
            if (j >= 0 && j < w)          r[i] = d[j];
            else if (mode == 2'b10)       r[i] = d[(j + w) % w];
            else if (mode == 2'b01 && dir) r[i] = d[w-1];
            else                          r[i] = 1'b0;
        end
        return r;
    endfunction

    // Records the handshakes that the coming rising edge will perform, then
    // advances to the next falling edge.
    task automatic tick();
        logic [31:0] m;
        exp_t        e;
        #1;
        accepted = 1'b0;
        if (in_valid && in_ready) begin
            m = ref_shift(8, {24'b0, in_data}, int'(in_shamt), in_dir, in_mode);
            e.data = m[7:0];
            e.step = step;
            sb.push_back(e);
            accepted = 1'b1;
        end
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("spurious_out", {31'b0, out_valid}, 32'd0);
            end else begin
                e = sb.pop_front();
                check("data", {24'b0, out_data}, {24'b0, e.data});
                if (lat_chk) check("latency", step - e.step, 32'd3);
            end
            last_out      = out_data;
            last_out_step = step;
            n_out++;
        end
        @(negedge clk);
        step++;
    endtask

    task automatic directed(input string tag, input logic [7:0] d, input logic [2:0] sh,
                            input logic dir, input logic [1:0] mode, input logic [7:0] exp);
        int n0;
        int budget;
        n0 = n_out;
        budget = 0;
        lat_chk = 1'b1;
        out_ready = 1'b1;
        in_valid = 1'b1; in_data = d; in_shamt = sh; in_dir = dir; in_mode = mode;
        tick();
        check({tag, "_accept"}, {31'b0, accepted}, 32'd1);
        in_valid = 1'b0;
        while (n_out == n0 && budget < 20) begin
            tick();
            budget++;
        end
        check({tag, "_done"}, n_out - n0, 32'd1);
        check(tag, {24'b0, last_out}, {24'b0, exp});
        lat_chk = 1'b0;
    endtask

    task automatic stream(input int stall_at, input int stall_len);
        int sent;
        int n0;
        int first;
        sent = 0;
        n0 = n_out;
        first = -1;
        for (int t = 0; t < 60 && (sent < 8 || sb.size() > 0); t++) begin
            in_valid = (sent < 8); in_data = 8'(sent + 1);
            in_shamt = 3'd1; in_dir = 1'b0; in_mode = 2'b00;
            out_ready = !(t >= stall_at && t < stall_at + stall_len);
            if (!out_ready) begin
                logic [7:0] snap;
                #1;
                snap = out_data;
                check("stall_valid", {31'b0, out_valid}, 32'd1);
                check("stall_in_ready", {31'b0, in_ready}, 32'd0);
                @(posedge clk);
                #1;
                check("stall_data_hold", {24'b0, out_data}, {24'b0, snap});
                check("stall_valid_hold", {31'b0, out_valid}, 32'd1);
                @(negedge clk);
                step++;
            end else begin
                #1;
                if (out_valid && first < 0) first = step;
                tick();
                if (accepted) sent++;
            end
        end
        in_valid = 1'b0; out_ready = 1'b1;
        check("stream_count", n_out - n0, 32'd8);
        if (stall_len == 0) check("stream_span", last_out_step - first, 32'd7);
    endtask

    task automatic run16(input string tag, input logic [15:0] d, input logic [3:0] sh,
                         input logic dir, input logic [1:0] mode, input logic [15:0] exp);
        int lat;
        in_valid16 = 1'b1; in_data16 = d; in_shamt16 = sh; in_dir16 = dir; in_mode16 = mode;
        #1;
        check({tag, "_in_ready"}, {31'b0, in_ready16}, 32'd1);
        @(negedge clk);
        in_valid16 = 1'b0;
        lat = 1;
        #1;
        while (!out_valid16 && lat < 12) begin
            @(negedge clk);
            lat++;
            #1;
        end
        check({tag, "_latency"}, lat, 32'd4);
        check(tag, {16'b0, out_data16}, {16'b0, exp});
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] m;
        int sent;
        int prev_step;
        rst = 1'b1;
        in_valid = 1'b0; in_data = '0; in_shamt = '0; in_dir = 1'b0; in_mode = '0; out_ready = 1'b1;
        in_valid16 = 1'b0; in_data16 = '0; in_shamt16 = '0; in_dir16 = 1'b0; in_mode16 = '0;
        out_ready16 = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_out_data", {24'b0, out_data}, 32'd0);
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);
        check("rst_out_valid16", {31'b0, out_valid16}, 32'd0);
        @(negedge clk);

        directed("arith_r3",   8'h96, 3'd3, 1'b1, 2'b01, 8'hF2);
        directed("rotl3",      8'h96, 3'd3, 1'b0, 2'b10, 8'hB4);
        directed("logic_r3",   8'h96, 3'd3, 1'b1, 2'b00, 8'h12);
        directed("logic_l5",   8'hFF, 3'd5, 1'b0, 2'b00, 8'hE0);
        directed("arith_r7",   8'h80, 3'd7, 1'b1, 2'b01, 8'hFF);
        directed("logic_l7",   8'h81, 3'd7, 1'b0, 2'b00, 8'h80);
        directed("rotr7",      8'h81, 3'd7, 1'b1, 2'b10, 8'h03);
        directed("zero_rot",   8'h5C, 3'd0, 1'b1, 2'b10, 8'h5C);
        directed("zero_arith", 8'hA7, 3'd0, 1'b1, 2'b01, 8'hA7);
        directed("mode11_r3",  8'h96, 3'd3, 1'b1, 2'b11, 8'h12);
        directed("mode11_l2",  8'h96, 3'd2, 1'b0, 2'b11, 8'h58);

        stream(0, 0);
        stream(5, 4);

        // Bubbles: alternate in_valid, expect outputs spaced by two cycles.
        lat_chk = 1'b1;
        out_ready = 1'b1;
        sent = 0;
        prev_step = -1;
        for (int t = 0; t < 40 && (sent < 4 || sb.size() > 0); t++) begin
            int n0;
            n0 = n_out;
            in_valid = (sent < 4) && (t % 2 == 0);
            in_data = 8'($urandom); in_shamt = 3'($urandom); in_dir = 1'($urandom);
            in_mode = 2'($urandom);
            tick();
            if (accepted) sent++;
            if (n_out != n0) begin
                if (prev_step >= 0) check("bubble_spacing", last_out_step - prev_step, 32'd2);
                prev_step = last_out_step;
            end
        end
        lat_chk = 1'b0;
        in_valid = 1'b0;

        // Reset with three items in flight and the output stalled.
        out_ready = 1'b0;
        for (int t = 0; t < 3; t++) begin
            in_valid = 1'b1; in_data = 8'(8'h11 * (t + 1)); in_shamt = 3'd2;
            in_dir = 1'b0; in_mode = 2'b00;
            tick();
        end
        in_valid = 1'b0;
        #1;
        check("pre_rst_valid", {31'b0, out_valid}, 32'd1);
        #1;
        rst = 1'b1;
        #1;
        check("midrst_out_valid", {31'b0, out_valid}, 32'd0);
        check("midrst_out_data", {24'b0, out_data}, 32'd0);
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        repeat (6) tick();
        directed("post_rst", 8'h3C, 3'd1, 1'b1, 2'b00, 8'h1E);

        // Randomized traffic with random backpressure.
        sent = 0;
        for (int t = 0; t < 3000 && (sent < 300 || sb.size() > 0); t++) begin
            in_valid = (sent < 300) && ($urandom_range(3) != 0);
            in_data = 8'($urandom); in_shamt = 3'($urandom); in_dir = 1'($urandom);
            in_mode = 2'($urandom);
            out_ready = ($urandom_range(9) < 7);
            tick();
            if (accepted) sent++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        check("random_drained", sb.size(), 32'd0);
        check("random_sent", sent, 32'd300);

        run16("w16_rotr9",   16'h8001, 4'd9,  1'b1, 2'b10, 16'h00C0);
        run16("w16_arith15", 16'h8000, 4'd15, 1'b1, 2'b01, 16'hFFFF);
        for (int i = 0; i < 20; i++) begin
            logic [15:0] d;
            logic [3:0]  sh;
            logic        dir;
            logic [1:0]  mode;
            d = 16'($urandom); sh = 4'($urandom); dir = 1'($urandom); mode = 2'($urandom);
            m = ref_shift(16, {16'b0, d}, int'(sh), dir, mode);
            run16("w16_rand", d, sh, dir, mode, m[15:0]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/pipelined_barrel_shifter.md
Name: pipelined_barrel_shifter

Overview:
- Parametrised, pipelined successor to the team's 8-bit combinational MUX barrel shifter.
- Generalises data width and adds arithmetic-right and rotate modes.
- Registers the output of every log2 shift stage and wraps the pipe in a valid/ready stream handshake with backpressure.
- Sits in datapath/ALU streams where a single-cycle WIDTH-wide shift would limit clock frequency.

Parameters:
- WIDTH, 8, data width in bits; must be a power of two, at least 2.
- SHW, $clog2(WIDTH), shift-amount width and pipeline depth; derived, never overridden.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  request valid
- in_ready  output  1  request accepted when in_valid && in_ready
- in_data  input  WIDTH  operand
- in_shamt  input  SHW  shift amount, 0..WIDTH-1
- in_dir  input  1  0 = left, 1 = right
- in_mode  input  2  00 logical, 01 arithmetic, 10 rotate, 11 reserved (treated as logical)
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts when out_valid && out_ready
- out_data  output  WIDTH  shifted result

Behaviour:
- Reset: rst high asynchronously clears all stage valid bits and all data/control registers to 0. Consequently out_valid=0 and out_data=0, and in_ready=1 once rst is released.
- Reset mid-operation discards every in-flight item. No result for those items ever appears.
- Pipeline structure: stage k (k=0..SHW-1) shifts by 2^k when the carried shamt[k]=1, otherwise passes through. Each stage registers data, dir, mode, the remaining shamt bits, and a valid bit.
- Stage output is the stage-k register. Stage SHW-1 drives out_data and out_valid.
- Stall rule: adv = out_ready || !out_valid. in_ready = adv (combinational from out_ready; no other combinational in->out path).
- Shared enable: all stages advance together when adv=1. When adv=0, every register holds, including out_data and out_valid.
- Bubbles: an empty stage propagates valid=0 and is not compressed during a stall.
- Data/control registers load only when adv=1 and the upstream valid=1. Otherwise they hold their old value; only the valid bit is cleared.
- Latency: exactly SHW cycles from acceptance to out_valid when out_ready is held high. Throughput is 1 item/cycle.
- Ordering: results emerge strictly in acceptance order. No item is dropped or duplicated.
- Shift rules per stage, by s=2^k:
  - Logical left: zero-fill LSBs.
  - Logical right: zero-fill MSBs.
  - Arithmetic right: fill with the operand's original MSB, carried as a sign bit captured at acceptance.
  - Arithmetic left: identical to logical left.
  - Rotate left/right: bits shifted out re-enter at the opposite end.
  - Mode 11: identical to logical.
- shamt=0: out_data = in_data for every mode/dir.
- Maximum shift WIDTH-1:
  - Logical left leaves only bit0 moved to the MSB.
  - Arithmetic right yields all sign bits.
  - Rotate yields a rotate by WIDTH-1.
- Simultaneous output handshake and new input: both occur in the same cycle; the pipe advances by one.
- in_valid=0 with adv=1: a bubble enters stage 0. in_data, in_shamt, in_dir and in_mode are ignored when not accepted.

Test Plan:
- Basic modes, WIDTH=8, out_ready=1:
  - in_data=0x96, shamt=3, dir=1, mode=01 -> out_data=0xF2 exactly 3 cycles after acceptance.
  - Same operand, dir=0, mode=10 -> 0xB4.
  - Same operand, dir=1, mode=00 -> 0x12.
- Boundaries, WIDTH=8:
  - 0xFF, shamt=5, left logical -> 0xE0.
  - 0x80, shamt=7, arithmetic right -> 0xFF.
  - Any data with shamt=0 -> unchanged.
  - Mode 11 -> identical to mode 00.
- Streaming and backpressure:
  - Push 0x01..0x08 back-to-back with left logical, shamt=1.
  - Drop out_ready for 4 cycles mid-stream: out_data/out_valid stable and in_ready=0 during the stall.
  - Outputs are 0x02..0x10 in order with no loss or duplication.
  - With out_ready=1, the outputs occupy 8 consecutive cycles.
- Bubbles: alternate in_valid 1/0 with out_ready=1 -> out_valid alternates with the same spacing, and each result arrives at latency 3.
- Reset mid-flight: rst asserted between clock edges with 3 items in flight -> out_valid=0 and out_data=0 immediately; after release no stale result appears and the next accepted item completes normally.
- WIDTH=16 (SHW=4): 0x8001, shamt=9, right rotate -> 0x00C0 after 4 cycles; 0x8000, shamt=15, arithmetic right -> 0xFFFF.
